// File: rtl/mips32_dbg_pkg.sv
// Shared definitions for the post-halt register dump engine.
package mips32_dbg_pkg;

  localparam logic [7:0] DUMP_SOF = 8'hA5;
  localparam int         REG_AW   = 5;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    CNT,
    RD,
    CAP,
    SEND,
    CK,
    FIN
  } dump_state_t;

endpackage

// File: rtl/mips32_word_ser.sv
// 32-bit word to 4-byte MSB-first serializer with valid/ready and a last flag.
module mips32_word_ser (
  input  logic        clk1,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] word,
  output logic [7:0]  byte_out,
  output logic        valid,
  input  logic        ready,
  output logic        last
);

  logic [31:0] sreg;
  logic [1:0]  idx;

  // Byte index and valid flag: armed by load, advanced per handshake, dropped after byte 3
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      idx   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      idx   <= '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) begin
        valid <= 1'b0;
      end
    end
  end

  // Data shift register: the current byte always sits in the top 8 bits
  always_ff @(posedge clk1) begin
    if (load) begin
      sreg <= word;
    end else if (valid && ready) begin
      sreg <= {sreg[23:0], 8'h00};
    end
  end

  assign byte_out = sreg[31:24];
  assign last     = (idx == 2'd3);

endmodule

// File: rtl/mips32_reg_dump.sv
// Post-halt register-file dump: reads R0..R(NUM_REGS-1) through the debug port
// and streams A5, count, register bytes MSB-first, XOR checksum.
module mips32_reg_dump
  import mips32_dbg_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  output logic              rd_en,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [REG_AW-1:0] LAST_K     = REG_AW'(NUM_REGS - 1);
  localparam logic [7:0]        COUNT_BYTE = 8'(NUM_REGS);

  dump_state_t       state;
  dump_state_t       state_next;
  logic              halted_q;
  logic              rise;
  logic              abort;
  logic              accept;
  logic [REG_AW-1:0] k;
  logic              k_clr;
  logic              k_inc;
  logic [7:0]        checksum;
  logic              ck_clr;
  logic              ck_upd;
  logic [7:0]        hdr_data;
  logic [7:0]        hdr_data_next;
  logic              hdr_valid;
  logic              hdr_valid_next;
  logic              ser_load;
  logic              ser_clr;
  logic              ser_ready;
  logic              ser_valid;
  logic              ser_last;
  logic [7:0]        ser_byte;

  assign rise      = halted & ~halted_q;
  assign abort     = (state != IDLE) & ~halted;
  assign accept    = tx_valid & tx_ready;
  assign ser_ready = (state == SEND) & tx_ready;

  // Header/checksum bytes come from hdr_*, register bytes from the serializer;
  // the two valids are never high together.
  assign tx_valid = hdr_valid | ser_valid;
  assign tx_data  = ser_valid ? ser_byte : hdr_data;

  assign rd_en   = (state == RD);
  assign rd_addr = k;
  assign busy    = (state != IDLE) && (state != FIN);
  assign done    = (state == FIN);

  mips32_word_ser u_ser (
    .clk1     (clk1),
    .rst      (rst),
    .clr      (ser_clr),
    .load     (ser_load),
    .word     (rd_data),
    .byte_out (ser_byte),
    .valid    (ser_valid),
    .ready    (ser_ready),
    .last     (ser_last)
  );

  // State register, halted history, register index, checksum and header byte
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      halted_q  <= 1'b0;
      k         <= '0;
      checksum  <= '0;
      hdr_valid <= 1'b0;
      hdr_data  <= '0;
    end else begin
      state     <= state_next;
      halted_q  <= halted;
      hdr_valid <= hdr_valid_next;
      hdr_data  <= hdr_data_next;
      if (k_clr) begin
        k <= '0;
      end else if (k_inc) begin
        k <= k + 1'b1;
      end
      if (ck_clr) begin
        checksum <= '0;
      end else if (ck_upd) begin
        checksum <= checksum ^ ser_byte;
      end
    end
  end

  // Next-state and control decode; halted dropping mid-frame abandons the frame
  always_comb begin
    state_next     = state;
    hdr_valid_next = hdr_valid;
    hdr_data_next  = hdr_data;
    ser_load       = 1'b0;
    ser_clr        = 1'b0;
    ck_clr         = 1'b0;
    ck_upd         = 1'b0;
    k_clr          = 1'b0;
    k_inc          = 1'b0;
    if (abort) begin
      state_next     = IDLE;
      hdr_valid_next = 1'b0;
      ser_clr        = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next = SOF;
            ck_clr     = 1'b1;
            k_clr      = 1'b1;
          end
        end
        SOF: begin
          if (!hdr_valid) begin
            hdr_valid_next = 1'b1;
            hdr_data_next  = DUMP_SOF;
          end else if (accept) begin
            state_next    = CNT;
            hdr_data_next = COUNT_BYTE;
          end
        end
        CNT: begin
          if (accept) begin
            state_next     = RD;
            hdr_valid_next = 1'b0;
          end
        end
        RD: begin
          state_next = CAP;
        end
        CAP: begin
          ser_load   = 1'b1;
          state_next = SEND;
        end
        SEND: begin
          if (accept) begin
            ck_upd = 1'b1;
            if (ser_last) begin
              if (k == LAST_K) begin
                state_next     = CK;
                hdr_valid_next = 1'b1;
                hdr_data_next  = checksum ^ ser_byte;
              end else begin
                state_next = RD;
                k_inc      = 1'b1;
              end
            end
          end
        end
        CK: begin
          if (accept) begin
            state_next     = FIN;
            hdr_valid_next = 1'b0;
          end
        end
        FIN: begin
          state_next = IDLE;
        end
        default: begin
          state_next     = IDLE;
          hdr_valid_next = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_reg_dump.sv
// Bench for mips32_reg_dump: 32- and 6-register instances against a frame model.
module tb_mips32_reg_dump;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst;
  logic        tx_ready;
  logic        halted32, halted6;
  logic        rd_en32, rd_en6;
  logic [4:0]  rd_addr32, rd_addr6;
  logic [31:0] rd_data32, rd_data6;
  logic [7:0]  tx_data32, tx_data6;
  logic        tx_valid32, tx_valid6;
  logic        busy32, busy6, done32, done6;

  logic [31:0] rf [32];

  mips32_reg_dump #(.NUM_REGS(32)) dut32 (
    .clk1(clk1), .rst(rst), .halted(halted32), .rd_en(rd_en32), .rd_addr(rd_addr32),
    .rd_data(rd_data32), .tx_data(tx_data32), .tx_valid(tx_valid32), .tx_ready(tx_ready),
    .busy(busy32), .done(done32)
  );

  mips32_reg_dump #(.NUM_REGS(6)) dut6 (
    .clk1(clk1), .rst(rst), .halted(halted6), .rd_en(rd_en6), .rd_addr(rd_addr6),
    .rd_data(rd_data6), .tx_data(tx_data6), .tx_valid(tx_valid6), .tx_ready(tx_ready),
    .busy(busy6), .done(done6)
  );

  // Registered debug read port: data is valid the cycle after rd_en
  always @(posedge clk1) begin
    if (rd_en32) rd_data32 <= rf[rd_addr32];
    if (rd_en6)  rd_data6  <= rf[rd_addr6];
  end

  logic       sel6;
  logic       rdy_rand;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_done, o_rd_en;
  logic [4:0] o_rd_addr;

  always_comb begin
    o_data    = sel6 ? tx_data6  : tx_data32;
    o_valid   = sel6 ? tx_valid6 : tx_valid32;
    o_busy    = sel6 ? busy6     : busy32;
    o_done    = sel6 ? done6     : done32;
    o_rd_en   = sel6 ? rd_en6    : rd_en32;
    o_rd_addr = sel6 ? rd_addr6  : rd_addr32;
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] got[$];
  logic [4:0] addrs[$];
  int         done_cnt, cyc_idx, first_valid_idx, done_idx;
  logic       busy_at_done;
  logic       prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    got.delete();
    addrs.delete();
    done_cnt        = 0;
    cyc_idx         = 0;
    first_valid_idx = -1;
    done_idx        = -1;
    busy_at_done    = 1'b1;
    prev_stall      = 1'b0;
    prev_data       = 8'h00;
  endtask

  // One clock: drive tx_ready, then observe what the coming edge will do
  task automatic cyc();
    @(posedge clk1);
    #1;
    cyc_idx++;
    tx_ready = rdy_rand ? ($urandom_range(0, 99) < 40) : 1'b1;
    if (prev_stall) begin
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_data", 32'(o_data), 32'(prev_data));
    end
    prev_stall = o_valid & ~tx_ready;
    prev_data  = o_data;
    if (o_valid && first_valid_idx < 0) first_valid_idx = cyc_idx;
    if (o_valid && tx_ready) got.push_back(o_data);
    if (o_rd_en) addrs.push_back(o_rd_addr);
    if (o_done) begin
      done_cnt++;
      done_idx     = cyc_idx;
      busy_at_done = o_busy;
    end
  endtask

  // Reference frame built straight from the register contents
  task automatic check_frame(input string tag, input int n, input bit timing);
    logic [7:0] exp[$];
    logic [7:0] ck;
    logic [7:0] bv;
    int         bad;
    ck = 8'h00;
    exp.push_back(8'hA5);
    exp.push_back(8'(n));
    for (int r = 0; r < n; r++) begin
      for (int b = 3; b >= 0; b--) begin
        bv = rf[r][8*b +: 8];
        exp.push_back(bv);
        ck = ck ^ bv;
      end
    end
    exp.push_back(ck);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    bad = 0;
    for (int i = 0; i < exp.size() && i < got.size() && bad == 0; i++) begin
      if (got[i] !== exp[i]) bad = 1;
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    end
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, "_rd_cnt"}, 32'(addrs.size()), 32'(n));
    bad = 0;
    for (int i = 0; i < n && i < addrs.size() && bad == 0; i++) begin
      if (addrs[i] !== 5'(i)) bad = 1;
      chk($sformatf("%s_rd_addr%0d", tag, i), 32'(addrs[i]), 32'(i));
    end
    chk({tag, "_latency"}, 32'(first_valid_idx), 32'd2);
    if (timing) chk({tag, "_frame_cycles"}, 32'(done_idx - first_valid_idx), 32'(6 * n + 3));
  endtask

  task automatic frame(input string tag, input int n, input int budget, input bit timing);
    int c;
    clear_obs();
    if (sel6) halted6 = 1'b1;
    else      halted32 = 1'b1;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      cyc();
      c++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    repeat (3) cyc();
    check_frame(tag, n, timing);
  endtask

  // halted stays high: nothing more may be sent; then release halted
  task automatic hold_check(input string tag);
    clear_obs();
    repeat (40) cyc();
    chk({tag, "_hold_bytes"}, 32'(got.size()), 32'd0);
    chk({tag, "_hold_done"}, 32'(done_cnt), 32'd0);
    halted32 = 1'b0;
    halted6  = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    int c;
    rst      = 1'b0;
    tx_ready = 1'b1;
    halted32 = 1'b0;
    halted6  = 1'b0;
    sel6     = 1'b0;
    rdy_rand = 1'b0;
    clear_obs();
    #2 rst = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    chk("rst_tx_valid", 32'(tx_valid32), 32'd0);
    chk("rst_tx_data", 32'(tx_data32), 32'd0);
    chk("rst_busy", 32'(busy32), 32'd0);
    chk("rst_done", 32'(done32), 32'd0);
    chk("rst_rd_en", 32'(rd_en32), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr32), 32'd0);
    chk("rst_tx_valid6", 32'(tx_valid6), 32'd0);
    rst = 1'b0;
    repeat (2) cyc();

    // Reg[k] = k over 32 registers, sink always ready
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    frame("t1", 32, 400, 1'b1);
    chk("t1_checksum", 32'(got[$]), 32'h00);
    hold_check("t1");

    // Six-register program result
    sel6  = 1'b1;
    rf[0] = 32'd0;  rf[1] = 32'd10; rf[2] = 32'd20;
    rf[3] = 32'd25; rf[4] = 32'd30; rf[5] = 32'd55;
    frame("t2", 6, 200, 1'b1);
    chk("t2_checksum", 32'(got[$]), 32'h2E);
    hold_check("t2");
    sel6 = 1'b0;

    // Random backpressure on the 32-register frame
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    rdy_rand = 1'b1;
    frame("t3", 32, 3000, 1'b0);
    rdy_rand = 1'b0;
    hold_check("t3");

    // Abort after ten accepted bytes, then a fresh frame
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    clear_obs();
    halted32 = 1'b1;
    c = 0;
    while (got.size() < 10 && c < 500) begin
      cyc();
      c++;
    end
    chk("t4_ten_bytes", 32'(got.size()), 32'd10);
    cyc();
    halted32 = 1'b0;
    cyc();
    chk("t4_valid_drop", 32'(o_valid), 32'd0);
    chk("t4_busy_drop", 32'(o_busy), 32'd0);
    repeat (20) cyc();
    chk("t4_no_done", 32'(done_cnt), 32'd0);
    chk("t4_valid_idle", 32'(o_valid), 32'd0);
    frame("t4r", 32, 400, 1'b1);
    hold_check("t4r");

    // Reset in the middle of SEND with halted held high
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    clear_obs();
    halted32 = 1'b1;
    c = 0;
    while (got.size() < 20 && c < 500) begin
      cyc();
      c++;
    end
    chk("t5_twenty_bytes", 32'(got.size()), 32'd20);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx_valid", 32'(tx_valid32), 32'd0);
    chk("t5_rst_tx_data", 32'(tx_data32), 32'd0);
    chk("t5_rst_busy", 32'(busy32), 32'd0);
    chk("t5_rst_rd_addr", 32'(rd_addr32), 32'd0);
    repeat (2) @(posedge clk1);
    #1;
    rst = 1'b0;
    frame("t5", 32, 400, 1'b1);
    hold_check("t5");

    // Toggle halted low/high: exactly one more frame
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    frame("t6", 32, 400, 1'b1);
    hold_check("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips32_reg_dump.md
# mips32_reg_dump

Post-halt register-file readback engine for the two-phase pipelined MIPS32 core. It detects the core's HALTED assertion, reads the architectural registers one at a time through a registered debug read port, and streams them out as a framed byte stream over a valid/ready interface. The frame is a start byte, a count, the register bytes MSB-first, and an XOR checksum. It sits beside the core on the clk1 domain and feeds a host link (UART/JTAG bridge), so results can be checked without hierarchical probing.

## Interface
- NUM_REGS, 32: registers dumped, R0..R(NUM_REGS-1); legal 1..32.
- clk1  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- halted  in  1  core HALTED flag; held high while the core is stopped.
- rd_en  out  1  debug read strobe, one-cycle pulse.
- rd_addr  out  5  debug read register index.
- rd_data  in  32  register contents; valid the cycle after rd_en.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  sink accepts when tx_valid & tx_ready at an edge.
- busy  out  1  high from trigger until the checksum byte is accepted.
- done  out  1  one-cycle pulse after the checksum byte is accepted.

## Operation
- Reset values: all outputs 0; state IDLE; halted_q = 0; checksum = 0x00.
- Trigger: rise = halted & ~halted_q, where halted_q is the registered halted. Rise in IDLE starts a frame. Rise in any other state is ignored.
- Frame order: 0xA5, NUM_REGS[7:0], then for each k = 0..NUM_REGS-1 the bytes rd_data[31:24], [23:16], [15:8], [7:0], then the checksum. Total 4*NUM_REGS+3 bytes.
- Checksum: running XOR of register bytes only; header bytes are excluded. Cleared at trigger.
- FSM states:
  - IDLE -> SOF on rise.
  - SOF (0xA5) -> CNT on accept.
  - CNT -> RD on accept.
  - RD: pulse rd_en with rd_addr=k -> CAP.
  - CAP: latch rd_data into a 32-bit shift register, byte index=0 -> SEND.
  - SEND: on accept, XOR the byte into the checksum and advance the byte index. After byte 3: if k==NUM_REGS-1 -> CK, else k++ -> RD.
  - CK (checksum) -> FIN on accept.
  - FIN: pulse done -> IDLE.
- Abort: halted low in any non-IDLE state -> IDLE next edge. tx_valid drops, busy drops, no done. A pending unaccepted byte is discarded.
- Async reset mid-frame clears everything immediately. Because halted_q resets to 0, a still-high halted retriggers a fresh frame after reset release.
- tx_data and tx_valid are registered. tx_data is stable while tx_valid is high and tx_ready is low.

## Timing
- Rise sampled at edge N -> tx_valid=1, tx_data=0xA5 after edge N+1.
- With tx_ready tied high:
  - header: one byte per cycle.
  - each register: RD and CAP cost 2 bubble cycles, then 4 consecutive bytes.
  - full 32-register frame: 2 + 32*6 + 1 + 1(FIN) cycles from first valid to done.
- done asserts the cycle after the checksum handshake edge. busy falls on the same edge that done rises.
- rd_en is high exactly one cycle per register. rd_addr is held from RD through the end of that register's SEND.
- Backpressure: tx_ready low for any number of cycles stalls without loss or duplication.

## Structure
- Shared package mips32_dbg_pkg holds:
  - DUMP_SOF = 8'hA5
  - the dump_state_t enum (IDLE, SOF, CNT, RD, CAP, SEND, CK, FIN)
  - REG_AW = 5
- One natural sub-module: mips32_word_ser. It is a 32-bit to 4-byte MSB-first serializer with load, valid/ready and a last flag; the FSM drives its load and consumes last.

## Test plan
- Reg[k]=k, NUM_REGS=32, tx_ready=1, raise halted -> 131 bytes: A5 20 00 00 00 00 00 00 00 01 … 00 00 00 1F, checksum 00; one done pulse; rd_addr sequence 0..31.
- NUM_REGS=6, Reg = 0,10,20,25,30,55 (program result R1=0x0A, R2=0x14, R3=0x19, R4=0x1E, R5=0x37) -> A5 06, 24 register bytes, checksum 2E.
- Random tx_ready (≈40% high) on the 32-register frame -> byte sequence identical to the first test; tx_data never changes while tx_valid & ~tx_ready.
- Drop halted after the 10th byte accepted -> tx_valid low next cycle, busy low, no done. Re-raise halted -> a complete fresh frame starting A5.
- Assert rst mid-SEND while halted stays high -> outputs 0 immediately. After release, a rise is detected and a full frame with correct checksum follows.
- Hold halted high after done -> no second frame. Toggle halted low then high -> exactly one more frame.
